// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the fetch/data request handshakes and the RAM macro bus of mem_port_arbiter.
// Latency: none, wires only.
// Backpressure: none here; requesters hold req until their ack pulse.
// Ports: f_* fetch requester, d_* data requester, rdata/busy status, ram_* RAM macro side.
// Modports: slave = arbiter view, master = requesters + RAM view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_ack;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_re;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        output f_gnt, f_ack, d_gnt, d_ack, rdata, busy,
        output ram_addr, ram_wdata, ram_re, ram_we
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        input  f_gnt, f_ack, d_gnt, d_ack, rdata, busy,
        input  ram_addr, ram_wdata, ram_re, ram_we
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port RAM between the instruction-fetch and load/store paths.
// Latency: gnt 1 cycle after req is sampled in IDLE; store ack cycle 2, read ack cycle 2+WAIT_CYCLES.
// Backpressure: req is sampled only in IDLE; a requester waits (holding req) until granted.
// Ports: Clock/Reset (sync, active-high) plain; bus (slave modport) carries f_req/f_addr/f_gnt/f_ack,
//        d_req/d_we/d_addr/d_wdata/d_gnt/d_ack, rdata, busy, ram_addr/ram_wdata/ram_re/ram_we/ram_rdata.
//        All outputs are registered.
module mem_port_arbiter #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1,
    parameter int MAX_STREAK  = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    mem_port_arbiter_if.slave    bus
);
    localparam int SW = $clog2(MAX_STREAK + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Attributes of the access in flight; address and store data live in ram_addr/ram_wdata.
    typedef struct packed {
        logic owner_f;
        logic we;
    } acc_t;

    state_t        state;
    acc_t          acc;
    logic [SW-1:0] streak;
    logic [2:0]    wcnt;
    logic          fetch_wins;

    // Data wins a tie until it has been granted MAX_STREAK times in a row over a waiting fetch.
    assign fetch_wins = bus.f_req && (!bus.d_req || (streak == SW'(MAX_STREAK)));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= ST_IDLE;
            acc           <= '0;
            streak        <= '0;
            wcnt          <= '0;
            bus.f_gnt     <= 1'b0;
            bus.f_ack     <= 1'b0;
            bus.d_gnt     <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.rdata     <= '0;
            bus.busy      <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.ram_re    <= 1'b0;
            bus.ram_we    <= 1'b0;
        end else begin
            // Pulses default low; each is raised for exactly one state.
            bus.f_gnt  <= 1'b0;
            bus.d_gnt  <= 1'b0;
            bus.f_ack  <= 1'b0;
            bus.d_ack  <= 1'b0;
            bus.ram_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.f_req || bus.d_req) begin
                        state    <= ST_ACCESS;
                        bus.busy <= 1'b1;
                        if (fetch_wins) begin
                            acc          <= '{owner_f: 1'b1, we: 1'b0};
                            streak       <= '0;
                            bus.f_gnt    <= 1'b1;
                            bus.ram_addr <= bus.f_addr;
                            bus.ram_re   <= 1'b1;
                        end else begin
                            acc          <= '{owner_f: 1'b0, we: bus.d_we};
                            bus.d_gnt    <= 1'b1;
                            bus.ram_addr <= bus.d_addr;
                            if (bus.d_we) begin
                                bus.ram_we    <= 1'b1;
                                bus.ram_wdata <= bus.d_wdata;
                            end else begin
                                bus.ram_re <= 1'b1;
                            end
                            if (!bus.f_req) begin
                                streak <= '0;
                            end else if (streak != SW'(MAX_STREAK)) begin
                                streak <= streak + SW'(1);
                            end
                        end
                    end else begin
                        streak <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (acc.we || (WAIT_CYCLES == 0)) begin
                        // Zero-latency RAM: read data is already valid during ACCESS.
                        if (!acc.we) begin
                            bus.rdata <= bus.ram_rdata;
                        end
                        bus.ram_re <= 1'b0;
                        state      <= ST_DONE;
                        if (acc.owner_f) bus.f_ack <= 1'b1;
                        else             bus.d_ack <= 1'b1;
                    end else begin
                        wcnt  <= 3'(WAIT_CYCLES - 1);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wcnt == 3'd0) begin
                        bus.rdata  <= bus.ram_rdata;
                        bus.ram_re <= 1'b0;
                        state      <= ST_DONE;
                        if (acc.owner_f) bus.f_ack <= 1'b1;
                        else             bus.d_ack <= 1'b1;
                    end else begin
                        wcnt <= wcnt - 3'd1;
                    end
                end
                ST_DONE: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed stimulus for mem_port_arbiter with a transaction-level expectation model.
// Latency: n/a.
// Backpressure: requester tasks hold req until ack, as real requesters do.
module tb_mem_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int WC = 1;
    localparam int MS = 4;

    logic Clock = 1'b0;
    logic Reset;
    logic ram_init;
    always #5 Clock = ~Clock;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC), .MAX_STREAK(MS)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus(bus)
    );

    // RAM macro: synchronous write, combinational read while ram_re is high.
    logic [DW-1:0] ram [0:(1<<AW)-1];

    function automatic logic [DW-1:0] init_word(input int i);
        case (i)
            16:      return 32'hDEADBEEF;
            511:     return 32'hCAFEF00D;
            default: return 32'h5A000000 ^ (32'(i) * 32'h00010003);
        endcase
    endfunction

    always @(posedge Clock) begin
        if (ram_init) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= init_word(i);
        end else if (bus.ram_we) begin
            ram[bus.ram_addr] <= bus.ram_wdata;
        end
    end
    assign bus.ram_rdata = bus.ram_re ? ram[bus.ram_addr] : '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: one transaction at a time, outputs derived from the cycle offset into it.
    logic [DW-1:0] mmem [0:(1<<AW)-1];
    bit            rst_seen = 1'b0;
    bit            m_active = 1'b0;
    int            m_start  = 0;
    int            m_len    = 0;
    bit            m_f, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    int            streak   = 0;
    bit            e_fgnt, e_dgnt, e_fack, e_dack, e_busy, e_re, e_we;

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit free, fw, inx;
        int k;
        cyc++;
        if (ram_init) for (int i = 0; i < (1 << AW); i++) mmem[i] = init_word(i);
        if (Reset) begin
            rst_seen = 1'b1;
            m_active = 1'b0;
            streak   = 0;
            m_rdata  = '0;
        end else begin
            // One idle cycle follows each access before a new request can be taken.
            free = !m_active || (cyc >= m_start + m_len + 1);
            if (free) begin
                if (bus.f_req || bus.d_req) begin
                    fw       = bus.f_req && (!bus.d_req || streak == MS);
                    m_active = 1'b1;
                    m_start  = cyc;
                    if (fw) begin
                        m_f = 1'b1; m_we = 1'b0; m_addr = bus.f_addr;
                        streak = 0;
                    end else begin
                        m_f = 1'b0; m_we = bus.d_we; m_addr = bus.d_addr; m_wdata = bus.d_wdata;
                        streak = bus.f_req ? ((streak < MS) ? streak + 1 : MS) : 0;
                    end
                    m_len = m_we ? 2 : 2 + WC;
                end else begin
                    streak = 0;
                end
            end
        end
        k      = cyc - m_start + 1;
        inx    = !Reset && m_active && k >= 1 && k <= m_len;
        e_busy = inx;
        e_fgnt = inx && m_f && k == 1;
        e_dgnt = inx && !m_f && k == 1;
        e_fack = inx && m_f && k == m_len;
        e_dack = inx && !m_f && k == m_len;
        e_re   = inx && !m_we && k <= 1 + WC;
        e_we   = inx && m_we && k == 1;
        if (e_we) mmem[m_addr] = m_wdata;
        if (inx && !m_we && k == m_len) m_rdata = mmem[m_addr];
    endtask

    task automatic compare_step();
        if (rst_seen) begin
            check_bit("f_gnt", bus.f_gnt, e_fgnt);
            check_bit("d_gnt", bus.d_gnt, e_dgnt);
            check_bit("f_ack", bus.f_ack, e_fack);
            check_bit("d_ack", bus.d_ack, e_dack);
            check_bit("busy", bus.busy, e_busy);
            check_bit("ram_re", bus.ram_re, e_re);
            check_bit("ram_we", bus.ram_we, e_we);
            check_word("rdata", bus.rdata, m_rdata);
            if (e_re || e_we) check_word("ram_addr", 32'(bus.ram_addr), 32'(m_addr));
            if (e_we) check_word("ram_wdata", bus.ram_wdata, m_wdata);
        end
    endtask

    // Called right after a negedge; req is sampled at the following posedge.
    task automatic fetch_req(input logic [AW-1:0] a, output int g, output int ak);
        g = -1; ak = -1;
        bus.f_req = 1'b1; bus.f_addr = a;
        for (int n = 0; n < 200; n++) begin
            @(negedge Clock);
            if (bus.f_gnt) begin
                g = cyc;
                bus.f_addr = ~a;
            end
            if (bus.f_ack) begin
                ak = cyc;
                break;
            end
        end
        bus.f_req = 1'b0;
        if (ak < 0) check_bit("fetch_ack_timeout", bus.f_ack, 1'b1);
    endtask

    task automatic data_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input bit early, output int g, output int ak);
        g = -1; ak = -1;
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
        for (int n = 0; n < 200; n++) begin
            @(negedge Clock);
            if (bus.d_gnt) begin
                g = cyc;
                if (early) bus.d_req = 1'b0;
                bus.d_addr  = ~a;
                bus.d_wdata = ~wd;
            end
            if (bus.d_ack) begin
                ak = cyc;
                break;
            end
        end
        bus.d_req = 1'b0;
        if (ak < 0) check_bit("data_ack_timeout", bus.d_ack, 1'b1);
    endtask

    initial begin
        int fg, fa, dg, da, nb, n;
        int dgs[5];
        int das[5];
        Reset = 1'b1; ram_init = 1'b1;
        bus.f_req = 1'b0; bus.f_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        fork
            forever begin @(posedge Clock); model_step(); end
            forever begin @(negedge Clock); compare_step(); end
        join_none

        @(negedge Clock); ram_init = 1'b0;
        @(negedge Clock);
        check_bit("rst_busy", bus.busy, 1'b0);
        check_bit("rst_f_gnt", bus.f_gnt, 1'b0);
        check_bit("rst_ram_re", bus.ram_re, 1'b0);
        check_word("rst_rdata", bus.rdata, 32'h0);
        Reset = 1'b0;

        // Fetch read with one wait cycle.
        fetch_req(9'h010, fg, fa);
        check_word("t2_gnt_to_ack", 32'(fa - fg), 32'd2);
        check_word("t2_rdata", bus.rdata, 32'hDEADBEEF);
        @(negedge Clock);

        // Store leaves rdata alone.
        data_req(1'b1, 9'h05A, 32'h12345678, 1'b0, dg, da);
        check_word("t3_gnt_to_ack", 32'(da - dg), 32'd1);
        check_word("t3_rdata_kept", bus.rdata, 32'hDEADBEEF);
        @(negedge Clock);
        check_word("t3_ram_written", ram[9'h05A], 32'h12345678);

        // Tie: data first, fetch on the next idle grant.
        fork
            fetch_req(9'h020, fg, fa);
            data_req(1'b0, 9'h030, 32'h0, 1'b0, dg, da);
        join
        check_bit("t4_data_first", dg < fg, 1'b1);
        check_word("t4_fetch_gap", 32'(fg - dg), 32'd4);
        check_word("t4_rdata", bus.rdata, 32'h5A200060);
        @(negedge Clock);

        // Starvation: four data grants, then fetch is forced.
        fork
            fetch_req(9'h044, fg, fa);
            begin
                for (int i = 0; i < 5; i++) begin
                    data_req(1'b0, AW'(80 + i), 32'h0, 1'b0, dgs[i], das[i]);
                    @(negedge Clock);
                end
            end
        join
        nb = 0;
        for (int i = 0; i < 5; i++) if (dgs[i] < fg) nb++;
        check_word("t5_data_before_fetch", 32'(nb), 32'd4);
        check_bit("t5_data_after_fetch", dgs[4] > fg, 1'b1);

        // Request dropped in the grant cycle still completes.
        data_req(1'b0, 9'h1FF, 32'h0, 1'b1, dg, da);
        check_word("t6_gnt_to_ack", 32'(da - dg), 32'd2);
        check_word("t6_rdata", bus.rdata, 32'hCAFEF00D);
        n = 0;
        repeat (4) begin @(negedge Clock); if (bus.d_ack) n++; end
        check_word("t6_extra_acks", 32'(n), 32'd0);

        // Reset in the middle of a fetch wait.
        bus.f_req = 1'b1; bus.f_addr = 9'h040;
        for (int k = 0; k < 50; k++) begin
            @(negedge Clock);
            if (bus.f_gnt) break;
        end
        check_bit("t1_gnt", bus.f_gnt, 1'b1);
        @(negedge Clock);
        check_bit("t1_wait_re", bus.ram_re, 1'b1);
        Reset = 1'b1; bus.f_req = 1'b0;
        n = 0;
        repeat (2) begin @(negedge Clock); if (bus.f_ack) n++; end
        Reset = 1'b0;
        check_bit("t1_busy", bus.busy, 1'b0);
        check_bit("t1_ram_re", bus.ram_re, 1'b0);
        check_word("t1_rdata", bus.rdata, 32'h0);
        repeat (4) begin @(negedge Clock); if (bus.f_ack) n++; end
        check_word("t1_no_ack", 32'(n), 32'd0);

        repeat (3) @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
